dht11_sensor_emu: RTL and testbench
===================================

DHT11_SENSOR_EMU -- requirements
Module: dht11_sensor_emu

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 12_000_000, clk frequency in Hz. CYC_US = CLK_FREQ/1_000_000.
REQ-002 SHALL have parameter START_MIN_US, default 10_000, minimum host low pulse in us accepted as a start request.
REQ-003 SHALL have port clk, input, 1, system clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous, active-low reset.
REQ-005 SHALL have port dht_in, input, 1, raw DHT line level (asynchronous).
REQ-006 SHALL have port dht_oe, output, 1, 1 = pull line low, 0 = release line.
REQ-007 SHALL have ports hum_int, hum_dec, tmp_int, tmp_dec, each input, 8, payload bytes.
REQ-008 SHALL have port busy, output, 1, high while a frame is in progress.
REQ-009 SHALL have port frame_done, output, 1, one-cycle pulse at frame end.
REQ-010 SHALL have port frame_count, output, 8, number of completed frames.

Function
REQ-011 SHALL sample dht_in through a 2-flop synchronizer; all decisions SHALL use the synchronized level (lin).
REQ-012 SHALL implement states IDLE, HOST_LOW, RESP_DLY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, TAIL_LOW with a single 18-bit phase counter that saturates at its maximum.
REQ-013 IDLE: lin=0 -> HOST_LOW with counter cleared.
REQ-014 HOST_LOW: counter increments while lin=0. On lin=1, if counter >= START_MIN_US*CYC_US then -> RESP_DLY; otherwise -> IDLE with no response.
REQ-015 On HOST_LOW->RESP_DLY, SHALL latch the four payload bytes and checksum = (hum_int+hum_dec+tmp_int+tmp_dec) mod 256. Input changes after the latch SHALL NOT affect the frame.
REQ-016 Phase durations, in clk cycles, counted from state entry:
- RESP_DLY: 30*CYC_US, dht_oe=0.
- RESP_LOW: 80*CYC_US, dht_oe=1.
- RESP_HIGH: 80*CYC_US, dht_oe=0.
- BIT_LOW: 50*CYC_US, dht_oe=1.
- BIT_HIGH: 26*CYC_US for bit 0 or 70*CYC_US for bit 1, dht_oe=0.
- TAIL_LOW: 50*CYC_US, dht_oe=1.
REQ-017 Bit order SHALL be 40 bits: hum_int, hum_dec, tmp_int, tmp_dec, checksum, each byte MSB first. Bit index runs 0..39. After BIT_HIGH of bit 39 -> TAIL_LOW, otherwise -> BIT_LOW.
REQ-018 TAIL_LOW expiry -> IDLE, dht_oe=0. frame_done SHALL pulse for one cycle and frame_count SHALL increment, wrapping 255->0.
REQ-019 busy SHALL be 1 in every state from RESP_DLY through TAIL_LOW inclusive, and 0 in IDLE and HOST_LOW.
REQ-020 lin SHALL be ignored in every state from RESP_DLY through TAIL_LOW; host glitches SHALL NOT abort or restart a frame.
REQ-021 A host low pulse longer than the counter range SHALL saturate the counter and still qualify as a start.
REQ-022 dht_oe SHALL be registered and glitch-free.

Reset
REQ-023 reset_n low SHALL asynchronously force: state=IDLE, dht_oe=0, busy=0, frame_done=0, frame_count=0, counter=0, bit index=0, latched bytes=0, synchronizer=1.
REQ-024 Reset mid-frame SHALL release the line immediately. The next qualifying start after reset_n deasserts SHALL produce a complete frame.

Configuration
REQ-025 Macro DHT11_EMU_FAULT_EN, when defined, SHALL add port inject_fault, input, 1. It is sampled at the latch of REQ-015; when 1, the transmitted checksum SHALL be bitwise inverted.
REQ-026 Without DHT11_EMU_FAULT_EN, the port SHALL NOT exist and the checksum SHALL always be correct.

Verification
REQ-027 Host drives low 18 ms then releases; payload 0x37,0x00,0x19,0x00 -> dht_oe rises 30 us (+2 sync cycles) after release, 80/80 response, 40 bits 0x37 00 19 00 50, 50 us tail, frame_done pulse, frame_count=1.
REQ-028 Host low 5 ms then release -> dht_oe stays 0, busy stays 0, frame_count unchanged.
REQ-029 Payload 0xFF,0xFF,0x01,0x02 -> checksum byte 0x01; bit-0 high phases 312 cycles, bit-1 high phases 840 cycles at 12 MHz.
REQ-030 Host pulls line low for 10 us during RESP_HIGH and again during bit 20 -> frame unaffected, same bit stream as a clean run.
REQ-031 reset_n asserted during BIT_LOW of bit 17 -> dht_oe=0 within the same cycle, frame_count=0; a following 18 ms start -> full correct frame.
REQ-032 With DHT11_EMU_FAULT_EN and inject_fault=1, payload 0x37,0x00,0x19,0x00 -> checksum byte transmitted as 0xAF.

Source files
------------

// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu: DHT11 sensor emulator; answers a qualified host start pulse with a 40-bit frame.
// Optional macro DHT11_EMU_FAULT_EN adds inject_fault, which inverts the transmitted checksum.
module dht11_sensor_emu #(
  parameter int CLK_FREQ     = 12_000_000,
  parameter int START_MIN_US = 10_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       dht_in,
`ifdef DHT11_EMU_FAULT_EN
  input  logic       inject_fault,
`endif
  output logic       dht_oe,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] tmp_int,
  input  logic [7:0] tmp_dec,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count
);
  localparam int CYC_US = CLK_FREQ / 1_000_000;
  localparam logic [17:0] START_CYC = 18'(START_MIN_US * CYC_US);
  localparam logic [17:0] DLY_END   = 18'(30 * CYC_US - 1);
  localparam logic [17:0] RESP_END  = 18'(80 * CYC_US - 1);
  localparam logic [17:0] LOW_END   = 18'(50 * CYC_US - 1);
  localparam logic [17:0] ZERO_END  = 18'(26 * CYC_US - 1);
  localparam logic [17:0] ONE_END   = 18'(70 * CYC_US - 1);

  typedef enum logic [2:0] {IDLE, HOST_LOW, RESP_DLY, RESP_LOW, RESP_HIGH, BIT_LOW, BIT_HIGH, TAIL_LOW} state_t;

  state_t      state_q, state_d;
  logic [1:0]  sync_q;
  logic [17:0] cnt_q, cnt_d, end_cnt;
  logic [5:0]  bit_q, bit_d;
  logic [39:0] data_q, data_d;
  logic        dht_oe_q, dht_oe_d, frame_done_q, frame_done_d;
  logic [7:0]  frame_count_q, frame_count_d, cs;
  logic        lin, qualified, expired;

  assign lin         = sync_q[1];
  assign dht_oe      = dht_oe_q;
  assign frame_done  = frame_done_q;
  assign frame_count = frame_count_q;
  assign busy        = !(state_q == IDLE || state_q == HOST_LOW);

  always_comb begin
    cs = hum_int + hum_dec + tmp_int + tmp_dec;
`ifdef DHT11_EMU_FAULT_EN
    cs = cs ^ {8{inject_fault}};
`endif
    qualified = cnt_q >= START_CYC;
    end_cnt = state_q == RESP_DLY ? DLY_END :
              (state_q == RESP_LOW || state_q == RESP_HIGH) ? RESP_END :
              state_q == BIT_HIGH ? (data_q[39] ? ONE_END : ZERO_END) : LOW_END;
    expired = cnt_q == end_cnt;
    state_d = state_q;
    cnt_d = &cnt_q ? cnt_q : cnt_q + 18'd1;
    bit_d = bit_q;
    data_d = data_q;
    frame_done_d = 1'b0;
    frame_count_d = frame_count_q;
    case (state_q)
      IDLE:      if (!lin) state_d = HOST_LOW;
      HOST_LOW:  if (lin) begin
        state_d = qualified ? RESP_DLY : IDLE;
        if (qualified) begin
          data_d = {hum_int, hum_dec, tmp_int, tmp_dec, cs};
          bit_d = '0;
        end
      end
      RESP_DLY:  if (expired) state_d = RESP_LOW;
      RESP_LOW:  if (expired) state_d = RESP_HIGH;
      RESP_HIGH: if (expired) state_d = BIT_LOW;
      BIT_LOW:   if (expired) state_d = BIT_HIGH;
      BIT_HIGH:  if (expired) begin
        state_d = bit_q == 6'd39 ? TAIL_LOW : BIT_LOW;
        bit_d = bit_q + 6'd1;
        data_d = data_q << 1;
      end
      TAIL_LOW:  if (expired) begin
        state_d = IDLE;
        frame_done_d = 1'b1;
        frame_count_d = frame_count_q + 8'd1;
      end
    endcase
    // every phase is timed from its own entry
    if (state_d != state_q) cnt_d = '0;
    dht_oe_d = state_d == RESP_LOW || state_d == BIT_LOW || state_d == TAIL_LOW;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      sync_q        <= 2'b11;
      cnt_q         <= '0;
      bit_q         <= '0;
      data_q        <= '0;
      dht_oe_q      <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      sync_q        <= {sync_q[0], dht_in};
      cnt_q         <= cnt_d;
      bit_q         <= bit_d;
      data_q        <= data_d;
      dht_oe_q      <= dht_oe_d;
      frame_done_q  <= frame_done_d;
      frame_count_q <= frame_count_d;
    end
  end
endmodule

// File: tb/tb_dht11_sensor_emu.sv
// tb_dht11_sensor_emu: bench for the DHT11 emulator at 1 MHz (1 cycle per us) with a 200 us start threshold.
module tb_dht11_sensor_emu;
  localparam int CLK_FREQ = 1_000_000, START_MIN_US = 200, C = 1;
  localparam int D = 30 * C, R = 80 * C, L = 50 * C, H0 = 26 * C, H1 = 70 * C;
  localparam int HOST_LONG = 500, HOST_SHORT = 100;

  typedef struct packed {logic oe; logic bsy; logic dn; logic [7:0] cnt;} exp_t;

  logic clk = 0, reset_n = 0, dht_in = 1, inject_fault = 0;
  logic dht_oe, busy, frame_done;
  logic [7:0] hum_int = 0, hum_dec = 0, tmp_int = 0, tmp_dec = 0, frame_count;
  exp_t exp_q[$];
  int checks = 0, passes = 0;
  logic [7:0] model_cnt = 0;
  logic [39:0] rx = 0;
  int run = 0, nrun = 0, hi0 = 0, hi1 = 0;
  logic prev_oe = 0, prev_busy = 0;

  dht11_sensor_emu #(.CLK_FREQ(CLK_FREQ), .START_MIN_US(START_MIN_US)) dut (
    .clk(clk), .reset_n(reset_n), .dht_in(dht_in),
`ifdef DHT11_EMU_FAULT_EN
    .inject_fault(inject_fault),
`endif
    .dht_oe(dht_oe), .hum_int(hum_int), .hum_dec(hum_dec), .tmp_int(tmp_int), .tmp_dec(tmp_dec),
    .busy(busy), .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // model: frame content from plain byte arithmetic
  function automatic logic [39:0] frame_bits(input int a, b, c, d, input bit flt);
    int s;
    s = (a + b + c + d) % 256;
    if (flt) s = 255 - s;
    return {8'(a), 8'(b), 8'(c), 8'(d), 8'(s)};
  endfunction

  function automatic int rem_from_bit(input logic [39:0] bits, input int k);
    int r = L + 4;
    for (int j = k; j < 40; j++) r += L + (bits[39 - j] ? H1 : H0);
    return r;
  endfunction

  task automatic push_n(input int n, input logic oe, input logic bsy, input logic dn, input logic [7:0] c);
    repeat (n) exp_q.push_back(exp_t'({oe, bsy, dn, c}));
  endtask

  // expected per-cycle outputs from the second RESP_LOW cycle to a few idle cycles after the frame
  task automatic push_frame(input logic [39:0] bits);
    push_n(R - 1, 1, 1, 0, model_cnt);
    push_n(R, 0, 1, 0, model_cnt);
    for (int j = 0; j < 40; j++) begin
      push_n(L, 1, 1, 0, model_cnt);
      push_n(bits[39 - j] ? H1 : H0, 0, 1, 0, model_cnt);
    end
    push_n(L, 1, 1, 0, model_cnt);
    model_cnt++;
    push_n(1, 0, 0, 1, model_cnt);
    push_n(3, 0, 0, 0, model_cnt);
  endtask

  task automatic wait_q(input int lvl);
    int n = 0;
    while (exp_q.size() > lvl && n < 20000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic host_start(input int len);
    dht_in = 0;
    repeat (len) @(negedge clk);
    dht_in = 1;
  endtask

  task automatic run_frame(input logic [7:0] a, b, c, d, input bit flt, input bit glitch, input int abort_bit);
    logic [39:0] bits;
    int n = 0;
    logic pb = 0;
    bits = frame_bits(a, b, c, d, flt);
    hum_int = a; hum_dec = b; tmp_int = c; tmp_dec = d; inject_fault = flt;
    host_start(HOST_LONG);
    while (!dht_oe && n < 100) begin
      pb = busy;
      @(negedge clk);
      n++;
    end
    check("start_latency_ok", 64'(n >= D + 2 && n <= D + 3), 1);
    check("busy_before_rise", 64'(pb), 1);
    if (!dht_oe) return;
    hum_int = ~a; hum_dec = ~b; tmp_int = ~c; tmp_dec = ~d; inject_fault = ~flt;
    @(posedge clk);
    push_frame(bits);
    if (glitch) begin
      wait_q(R + rem_from_bit(bits, 0) - 20);
      host_start(10 * C);
      wait_q(rem_from_bit(bits, 20) - 5);
      host_start(10 * C);
    end
    if (abort_bit >= 0) begin
      wait_q(rem_from_bit(bits, abort_bit) - 5);
      check("oe_before_reset", 64'(dht_oe), 1);
      #2 reset_n = 0;
      exp_q.delete();
      model_cnt = 0;
      #1;
      check("reset_oe", 64'(dht_oe), 0);
      check("reset_busy", 64'(busy), 0);
      check("reset_count", 64'(frame_count), 0);
      @(negedge clk);
      reset_n = 1;
      return;
    end
    wait_q(0);
    check("frame_complete", 64'(exp_q.size()), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("dht_oe", 64'(dht_oe), 64'(e.oe));
      check("busy", 64'(busy), 64'(e.bsy));
      check("frame_done", 64'(frame_done), 64'(e.dn));
      check("frame_count", 64'(frame_count), 64'(e.cnt));
    end
  end

  // decodes released-line run lengths back into bits for literal payload checks
  always @(negedge clk) begin
    if (busy && !prev_busy) begin
      nrun = 0;
      run = 0;
    end
    if (busy && dht_oe && !prev_oe) begin
      if (nrun >= 2) begin
        rx = {rx[38:0], run > (H0 + H1) / 2};
        if (run > (H0 + H1) / 2) hi1 = run; else hi0 = run;
      end
      nrun++;
      run = 0;
    end
    if (busy && !dht_oe) run++;
    prev_oe = dht_oe;
    prev_busy = busy;
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_oe", 64'(dht_oe), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(frame_done), 0);
    check("rst_count", 64'(frame_count), 0);
    reset_n = 1;
    repeat (3) @(negedge clk);
    run_frame(8'h37, 8'h00, 8'h19, 8'h00, 0, 0, -1);
    check("rx_frame1", 64'(rx), 64'h37_00_19_00_50);
    check("count_frame1", 64'(frame_count), 1);
    host_start(HOST_SHORT);
    @(posedge clk);
    push_n(3 * D, 0, 0, 0, model_cnt);
    wait_q(0);
    check("count_short", 64'(frame_count), 1);
    run_frame(8'hFF, 8'hFF, 8'h01, 8'h02, 0, 0, -1);
    check("rx_frame_ff", 64'(rx), 64'hFF_FF_01_02_01);
    check("bit0_high_len", 64'(hi0), 26);
    check("bit1_high_len", 64'(hi1), 70);
    check("count_frame2", 64'(frame_count), 2);
    run_frame(8'h37, 8'h00, 8'h19, 8'h00, 0, 1, -1);
    check("rx_glitch", 64'(rx), 64'h37_00_19_00_50);
    check("count_glitch", 64'(frame_count), 3);
    run_frame(8'h37, 8'h00, 8'h19, 8'h00, 0, 0, 17);
    repeat (3) @(negedge clk);
    run_frame(8'h37, 8'h00, 8'h19, 8'h00, 0, 0, -1);
    check("rx_after_reset", 64'(rx), 64'h37_00_19_00_50);
    check("count_after_reset", 64'(frame_count), 1);
`ifdef DHT11_EMU_FAULT_EN
    run_frame(8'h37, 8'h00, 8'h19, 8'h00, 1, 0, -1);
    check("rx_fault", 64'(rx), 64'h37_00_19_00_AF);
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
